// File: rtl/shadow_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : shadow_stack_unit
// Description : Hardware shadow return-address stack checking resolved
//               call/return pairs; raises a violation and a sticky crash
//               request on a return-target mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_stack_unit #(
    parameter int DEPTH = 16,
    parameter int VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       debug_mode_i,
    input  logic                       clear_i,
    input  logic                       valid_i,
    input  logic [VLEN-1:0]            pc_i,
    input  logic                       is_compressed_i,
    input  logic                       is_call_i,
    input  logic                       is_return_i,
    input  logic [VLEN-1:0]            target_i,
    output logic                       violation_o,
    output logic [VLEN-1:0]            violation_pc_o,
    output logic                       crash_req_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       overflow_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [VLEN-1:0]    c_cmp_mask = {{(VLEN-1){1'b1}}, 1'b0};

    logic [VLEN-1:0]    r_entry [DEPTH];
    logic [c_ptr_w-1:0] r_tp;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_violation;
    logic [VLEN-1:0]    r_violation_pc;
    logic               r_crash;
    logic               r_overflow;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_top_idx;
    logic [c_ptr_w-1:0] w_wr_idx;
    logic [VLEN-1:0]    w_ret_addr;
    logic               w_mismatch;
    logic               w_flag;

    // clear_i wins over any same-cycle resolve, so it also blocks acceptance
    assign w_accept   = valid_i && !debug_mode_i && !clear_i;
    assign w_push     = w_accept && is_call_i;
    assign w_pop      = w_accept && is_return_i && (r_cnt != '0);
    assign w_top_idx  = r_tp - c_ptr_one;
    assign w_ret_addr = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));

    // Bit 0 of the target is not architecturally meaningful for JALR
    assign w_mismatch = w_pop &&
                        ((r_entry[w_top_idx] & c_cmp_mask) != (target_i & c_cmp_mask));
    assign w_flag     = w_mismatch && en_i;

    // A combined call+return reuses the slot the pop just freed
    assign w_wr_idx   = w_pop ? w_top_idx : r_tp;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_entry[w_wr_idx] <= w_ret_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tp           <= '0;
            r_cnt          <= '0;
            r_violation    <= 1'b0;
            r_violation_pc <= '0;
            r_crash        <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (clear_i) begin
            r_tp        <= '0;
            r_cnt       <= '0;
            r_violation <= 1'b0;
            r_crash     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_violation <= w_flag;
            if (w_flag) begin
                r_violation_pc <= pc_i;
                r_crash        <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_tp <= r_tp + c_ptr_one;
                if (r_cnt == c_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else if (w_pop && !w_push) begin
                r_tp  <= w_top_idx;
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign violation_o    = r_violation;
    assign violation_pc_o = r_violation_pc;
    assign crash_req_o    = r_crash;
    assign depth_o        = r_cnt;
    assign overflow_o     = r_overflow;

endmodule
`default_nettype wire
